// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses RESETB, waits for a settled LOCK, then releases sys_reset.
// Optional bypass fallback after repeated lock timeouts: define PLL_BYPASS_FALLBACK_EN.
module pll_lock_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_SETTLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65535,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_resetb,
  output logic       pll_bypass,
  output logic       sys_reset,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retries
);

  localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_SETTLE_CYCLES) ? PLL_RST_CYCLES : LOCK_SETTLE_CYCLES;
  localparam int MAX_V  = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W  = $clog2(MAX_V + 1);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(LOCK_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT = 4'((MAX_RETRIES > 15) ? 15 : MAX_RETRIES);

  if (PLL_RST_CYCLES < 1 || LOCK_SETTLE_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1 || MAX_RETRIES < 1) begin : g_cfg_err
    $error("pll_lock_sequencer: cycle and retry parameters must all be >= 1");
  end

  typedef enum logic [2:0] {
    ST_RST_PLL,
    ST_WAIT_LOCK,
    ST_SETTLE,
    ST_RUN
`ifdef PLL_BYPASS_FALLBACK_EN
    , ST_BYPASS
`endif
  } state_t;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_lock_p0;
  logic             r_lock_s;
  logic             r_resetb, r_bypass, r_sys_reset, r_ready, r_fault;
  logic [3:0]       r_retries;
  logic             w_fault;
  logic [3:0]       w_retries;
  logic             w_active;
  logic             w_bypass;

  always_comb begin
    w_next    = r_state;
    w_fault   = 1'b0;
    w_retries = r_retries;
    case (r_state)
      ST_RST_PLL: begin
        if (r_cnt == RST_LAST) w_next = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (r_lock_s) begin
          w_next = ST_SETTLE;
        end else if (r_cnt == TO_LAST) begin
          w_fault   = 1'b1;
          w_retries = sat_inc(r_retries);
`ifdef PLL_BYPASS_FALLBACK_EN
          w_next    = (w_retries >= RETRY_LIMIT) ? ST_BYPASS : ST_RST_PLL;
`else
          w_next    = ST_RST_PLL;
`endif
        end
      end
      ST_SETTLE: begin
        // A lock drop on the final settle cycle still aborts the release.
        if (!r_lock_s) begin
          w_next = ST_WAIT_LOCK;
        end else if (r_cnt == SETTLE_LAST) begin
          w_next    = ST_RUN;
          w_retries = 4'd0;
        end
      end
      ST_RUN: begin
        if (!r_lock_s || relock_req) w_next = ST_RST_PLL;
      end
`ifdef PLL_BYPASS_FALLBACK_EN
      ST_BYPASS: begin
        if (relock_req) begin
          w_next    = ST_RST_PLL;
          w_retries = 4'd0;
        end
      end
`endif
      default: w_next = ST_RST_PLL;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    w_active = (w_next == ST_RUN);
    w_bypass = 1'b0;
`ifdef PLL_BYPASS_FALLBACK_EN
    w_bypass = (w_next == ST_BYPASS);
`endif
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RST_PLL;
      r_cnt       <= '0;
      r_lock_p0   <= 1'b0;
      r_lock_s    <= 1'b0;
      r_resetb    <= 1'b0;
      r_bypass    <= 1'b0;
      r_sys_reset <= 1'b1;
      r_ready     <= 1'b0;
      r_fault     <= 1'b0;
      r_retries   <= 4'd0;
    end else begin
      r_lock_p0   <= pll_lock;
      r_lock_s    <= r_lock_p0;
      r_state     <= w_next;
      if (w_next != r_state)
        r_cnt <= '0;
      else if (r_state == ST_RST_PLL || r_state == ST_WAIT_LOCK || r_state == ST_SETTLE)
        r_cnt <= r_cnt + CNT_W'(1);
      r_resetb    <= (w_next == ST_WAIT_LOCK) || (w_next == ST_SETTLE) || w_active;
      r_bypass    <= w_bypass;
      r_sys_reset <= !(w_active || w_bypass);
      r_ready     <= w_active || w_bypass;
      r_fault     <= w_fault;
      r_retries   <= w_retries;
    end
  end

  assign pll_resetb = r_resetb;
  assign pll_bypass = r_bypass;
  assign sys_reset  = r_sys_reset;
  assign ready      = r_ready;
  assign fault      = r_fault;
  assign retries    = r_retries;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short cycle parameters (4/8/32, 2 retries).
module tb_pll_lock_sequencer;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       pll_lock;
  logic       relock_req;
  logic       pll_resetb, pll_bypass, sys_reset, ready, fault;
  logic [3:0] retries;

  int n_chk  = 0;
  int n_pass = 0;

  pll_lock_sequencer #(
    .PLL_RST_CYCLES     (4),
    .LOCK_SETTLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .MAX_RETRIES        (2)
  ) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .pll_lock  (pll_lock),
    .relock_req(relock_req),
    .pll_resetb(pll_resetb),
    .pll_bypass(pll_bypass),
    .sys_reset (sys_reset),
    .ready     (ready),
    .fault     (fault),
    .retries   (retries)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("wait_ready", ready, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_resetb"},  pll_resetb, 0);
    check({tag, "_bypass"},  pll_bypass, 0);
    check({tag, "_sysrst"},  sys_reset,  1);
    check({tag, "_ready"},   ready,      0);
    check({tag, "_fault"},   fault,      0);
    check({tag, "_retries"}, retries,    0);
  endtask

  initial begin
    rst_n      = 1'b0;
    pll_lock   = 1'b0;
    relock_req = 1'b0;
    repeat (3) tick();
    check_reset_vals("rst");

    // Clean start: RESETB low for exactly 4 cycles after release
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("start_resetb", pll_resetb, (i == 4));
      check("start_sysrst", sys_reset, 1);
    end
    repeat (6) tick();
    pll_lock = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      check("lock_release_lat", sys_reset, (i < 11));
    end
    check("run_ready", ready, 1);
    check("run_retries", retries, 0);
    check("run_fault", fault, 0);

    // relock_req in RUN: back to RST_PLL on the next edge
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    check("relock_sysrst", sys_reset, 1);
    check("relock_resetb", pll_resetb, 0);
    check("relock_ready", ready, 0);
    repeat (4) tick();
    check("relock_wait_resetb", pll_resetb, 1);
    tick();
    repeat (5) tick();

    // Glitchy lock at settle count 5; the drop also lands on the final settle cycle
    pll_lock = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("glitch_sysrst", sys_reset, 1);
      check("glitch_fault", fault, 0);
    end
    pll_lock = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      check("glitch_resettle", sys_reset, (i < 11));
      check("glitch_fault2", fault, 0);
    end
    check("glitch_retries", retries, 0);
    check("glitch_ready", ready, 1);

    // relock_req and lock drop together: one transition, one 4-cycle RESETB pulse
    pll_lock   = 1'b0;
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    check("dual_sysrst", sys_reset, 1);
    check("dual_resetb", pll_resetb, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("dual_resetb_pulse", pll_resetb, (i == 4));
    end

    // Timeouts with lock held low
    for (int i = 1; i <= 32; i++) begin
      tick();
      check("to1_fault", fault, (i == 32));
    end
    check("to1_retries", retries, 1);
    check("to1_resetb", pll_resetb, 0);
    for (int i = 1; i <= 36; i++) begin
      tick();
      check("to2_fault", fault, (i == 36));
    end
    check("to2_retries", retries, 2);
`ifdef PLL_BYPASS_FALLBACK_EN
    check("byp_bypass", pll_bypass, 1);
    check("byp_sysrst", sys_reset, 0);
    check("byp_ready", ready, 1);
    check("byp_resetb", pll_resetb, 0);
    tick();
    check("byp_fault_clr", fault, 0);
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    check("byp_exit_bypass", pll_bypass, 0);
    check("byp_exit_sysrst", sys_reset, 1);
    check("byp_exit_retries", retries, 0);
    check("byp_exit_ready", ready, 0);
`else
    check("nobyp_bypass", pll_bypass, 0);
    check("nobyp_ready", ready, 0);
    for (int k = 3; k <= 16; k++) begin
      repeat (36) tick();
      check("nobyp_fault", fault, 1);
      check("nobyp_retries", retries, (k > 15) ? 15 : k);
    end
    check("nobyp_bypass_end", pll_bypass, 0);
`endif

    // Lock loss in RUN: reset reasserts on the third edge, then a full new sequence
    pll_lock = 1'b1;
    wait_ready(200);
    check("reacq_retries", retries, 0);
    tick();
    pll_lock = 1'b0;
    tick();
    check("loss_e1_sysrst", sys_reset, 0);
    tick();
    check("loss_e2_sysrst", sys_reset, 0);
    tick();
    check("loss_e3_sysrst", sys_reset, 1);
    check("loss_e3_resetb", pll_resetb, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("loss_resetb_pulse", pll_resetb, (i == 4));
    end
    pll_lock = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      check("loss_release_lat", sys_reset, (i < 11));
    end

    // Async reset mid-SETTLE, between clock edges
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    repeat (4) tick();
    tick();
    repeat (3) tick();
    check("pre_async_resetb", pll_resetb, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async");
    tick();
    check_reset_vals("async_hold");
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
